// File: rtl/sym8psk_pkg.sv
// sym8psk_pkg
//   Shared types and constants for the 8DPSK symbol mapper.
//   - state_t    : mapper FSM state encoding
//   - LEN_W_DEF  : default payload bit-length width
//   - CNT_W_DEF  : default symbol counter width
//   - gray_step  : Gray-coded bit triple -> phase step (units of pi/4)
package sym8psk_pkg;

    localparam int LEN_W_DEF = 12;
    localparam int CNT_W_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // b1 is the MSB of the triple
    function automatic logic [2:0] gray_step(input logic [2:0] triple);
        logic [2:0] step;
        case (triple)
            3'b000:  step = 3'd0;
            3'b001:  step = 3'd1;
            3'b011:  step = 3'd2;
            3'b010:  step = 3'd3;
            3'b110:  step = 3'd4;
            3'b111:  step = 3'd5;
            3'b101:  step = 3'd6;
            default: step = 3'd7;   // 3'b100
        endcase
        return step;
    endfunction

endpackage

// File: rtl/dpsk8_gray_map.sv
// dpsk8_gray_map
//   Combinational Gray map from a 3-bit payload triple to a phase step.
//   Ports:
//     triple  in   3  bit triple, b1 in bit 2
//     step    out  3  phase step in units of pi/4
module dpsk8_gray_map
    import sym8psk_pkg::*;
(
    input  logic [2:0] triple,
    output logic [2:0] step
);

    always_comb begin
        step = gray_step(triple);
    end

endmodule

// File: rtl/sym8psk_mapper.sv
// sym8psk_mapper
//   Packs the serial EDR payload into 3-bit triples, Gray-maps each to a
//   phase step and accumulates an absolute 8DPSK phase index. A trailing
//   partial triple is zero-padded. Counts symbols and pulses done_p once
//   the payload is exhausted.
//   Ports:
//     clk_6M     in   1      baseband clock
//     rst        in   1      asynchronous active-high reset
//     en_p       in   1      start pulse; samples len, clears phase/counters
//     len        in   LEN_W  payload length in bits
//     bit_in     in   1      payload bit (first bit of a triple is b1)
//     bit_valid  in   1      bit_in valid this cycle
//     sym_phase  out  3      absolute phase index (units of pi/4)
//     sym_valid  out  1      pulse, sym_phase updated this cycle
//     sym_count  out  CNT_W  symbols emitted since last en_p
//     busy       out  1      high while consuming payload
//     done_p     out  1      pulse alongside the last symbol
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | waiting for en_p; bits ignored, outputs hold
//   RUN   | consuming payload bits, emitting symbols
//   DONE  | one cycle, done_p high, then back to IDLE
module sym8psk_mapper
    import sym8psk_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             en_p,
    input  logic [LEN_W-1:0] len,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [2:0]       sym_phase,
    output logic             sym_valid,
    output logic [CNT_W-1:0] sym_count,
    output logic             busy,
    output logic             done_p
);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] bitcnt;
    logic [1:0]       slot;
    logic [2:0]       triple;
    logic [2:0]       triple_nxt;
    logic [2:0]       step;
    logic             accept;
    logic             last_bit;
    logic             sym_done;

    // len_q is never 0 while in RUN, so len_q-1 cannot underflow there
    assign last_bit = (bitcnt == len_q - LEN_W'(1));
    assign accept   = (state == ST_RUN) && bit_valid && !en_p;
    assign sym_done = accept && ((slot == 2'd2) || last_bit);

    // triple is cleared at every symbol boundary, so unfilled positions of a
    // short final triple are already zero
    always_comb begin
        triple_nxt = triple;
        case (slot)
            2'd0:    triple_nxt[2] = bit_in;
            2'd1:    triple_nxt[1] = bit_in;
            default: triple_nxt[0] = bit_in;
        endcase
    end

    dpsk8_gray_map u_gray_map (
        .triple (triple_nxt),
        .step   (step)
    );

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (en_p) state_nxt = (len == '0) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                if (en_p)                      state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                else if (bit_valid && last_bit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (en_p) state_nxt = (len == '0) ? ST_DONE : ST_RUN;
                else      state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            len_q     <= '0;
            bitcnt    <= '0;
            slot      <= '0;
            triple    <= '0;
            sym_phase <= '0;
            sym_count <= '0;
            sym_valid <= 1'b0;
        end else begin
            sym_valid <= 1'b0;
            if (en_p) begin
                len_q     <= len;
                bitcnt    <= '0;
                slot      <= '0;
                triple    <= '0;
                sym_phase <= '0;
                sym_count <= '0;
            end else if (accept) begin
                bitcnt <= bitcnt + LEN_W'(1);
                if (sym_done) begin
                    slot      <= '0;
                    triple    <= '0;
                    sym_phase <= sym_phase + step;
                    sym_count <= sym_count + CNT_W'(1);
                    sym_valid <= 1'b1;
                end else begin
                    slot   <= slot + 2'd1;
                    triple <= triple_nxt;
                end
            end
        end
    end

    assign busy   = (state == ST_RUN);
    assign done_p = (state == ST_DONE);

endmodule

// File: tb/tb_sym8psk_mapper.sv
module tb_sym8psk_mapper;

    localparam int LEN_W = 12;
    localparam int CNT_W = 11;

    typedef struct packed {
        logic [2:0]  phase;
        logic [15:0] count;
        logic        done;
    } exp_t;

    logic             clk_6M = 1'b0;
    logic             rst;
    logic             en_p;
    logic [LEN_W-1:0] len;
    logic             bit_in;
    logic             bit_valid;
    logic [2:0]       sym_phase;
    logic             sym_valid;
    logic [CNT_W-1:0] sym_count;
    logic             busy;
    logic             done_p;

    sym8psk_mapper #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk_6M    (clk_6M),
        .rst       (rst),
        .en_p      (en_p),
        .len       (len),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .sym_phase (sym_phase),
        .sym_valid (sym_valid),
        .sym_count (sym_count),
        .busy      (busy),
        .done_p    (done_p)
    );

    always #5 clk_6M = ~clk_6M;

    int   n_vec = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    // reference model state
    logic [2:0] gstep [8];
    logic [2:0] m_phase;
    logic [2:0] m_tri;
    int         m_count, m_slot, m_bits, m_len;
    bit         m_run;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk_6M) begin
        if (done_p) done_cnt++;
        if (sym_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_sym", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sym_phase", int'(sym_phase), int'(e.phase));
                chk("sym_count", int'(sym_count), int'(e.count));
                chk("done_with_sym", int'(done_p), int'(e.done));
            end
        end
    end

    // called #1 after a rising edge
    task automatic start(input int l);
        en_p = 1'b1;
        len  = LEN_W'(l);
        @(posedge clk_6M); #1;
        en_p = 1'b0;
        m_len = l; m_phase = 3'd0; m_count = 0; m_slot = 0; m_tri = 3'd0;
        m_bits = 0; m_run = (l != 0);
        chk("busy_after_en", int'(busy), int'(l != 0));
        chk("phase_clr", int'(sym_phase), 0);
        chk("count_clr", int'(sym_count), 0);
        chk("done_len0", int'(done_p), int'(l == 0));
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit last;
        bit_in    = b;
        bit_valid = 1'b1;
        if (m_run) begin
            m_tri[2 - m_slot] = b;
            m_bits++;
            last = (m_bits == m_len);
            if (m_slot == 2 || last) begin
                exp_t e;
                m_phase = m_phase + gstep[m_tri];
                m_count++;
                e.phase = m_phase;
                e.count = 16'(m_count);
                e.done  = last;
                sb.push_back(e);
                m_tri = 3'd0;
                m_slot = 0;
                if (last) m_run = 0;
            end else begin
                m_slot++;
            end
        end
        @(posedge clk_6M); #1;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        repeat (gap) begin
            @(posedge clk_6M); #1;
        end
    endtask

    task automatic send_bits(input logic [15:0] pat, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(pat[i], gap);
    endtask

    task automatic drain(input string tag);
        int budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk_6M); #1;
            budget--;
        end
        @(posedge clk_6M); #1;
        chk(tag, sb.size(), 0);
    endtask

    task automatic run_pkt(input int l, input logic [15:0] pat, input int gap, input string tag);
        int d0;
        d0 = done_cnt;
        start(l);
        send_bits(pat, l, gap);
        drain(tag);
        chk("done_pulses", done_cnt - d0, 1);
        chk("idle_after_pkt", int'(busy), 0);
    endtask

    initial begin
        gstep[0] = 3'd0; gstep[1] = 3'd1; gstep[3] = 3'd2; gstep[2] = 3'd3;
        gstep[6] = 3'd4; gstep[7] = 3'd5; gstep[5] = 3'd6; gstep[4] = 3'd7;
        m_run = 0;
        rst = 1'b1; en_p = 1'b0; len = '0; bit_in = 1'b0; bit_valid = 1'b0;
        #1;
        chk("rst_phase", int'(sym_phase), 0);
        chk("rst_count", int'(sym_count), 0);
        chk("rst_valid", int'(sym_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done_p), 0);
        @(posedge clk_6M); #1;
        rst = 1'b0;
        @(posedge clk_6M); #1;

        // phases 0,1
        run_pkt(6, 16'b000001, 0, "pkt6_drain");
        chk("hold_count_idle", int'(sym_count), 2);
        chk("hold_phase_idle", int'(sym_phase), 1);
        // 110 -> 4, padded 100 -> 3
        run_pkt(4, 16'b1101, 0, "pkt4_drain");
        // wrap: 7,6,5 with gaps between bits
        run_pkt(9, 16'b100100100, 2, "pkt9_drain");
        // restart from phase 0: 5
        run_pkt(3, 16'b111, 0, "pkt3_drain");

        // zero length: done_p only
        begin
            int d0;
            d0 = done_cnt;
            start(0);
            drain("pkt0_drain");
            chk("len0_done_pulses", done_cnt - d0, 1);
            chk("len0_count", int'(sym_count), 0);
        end

        // abort after 5 bits, then a full 12-bit packet
        begin
            int d0;
            d0 = done_cnt;
            start(12);
            send_bits(16'b10110, 5, 0);
            start(12);
            send_bits(16'b011010111100, 12, 1);
            drain("abort_drain");
            chk("abort_done_pulses", done_cnt - d0, 1);
            chk("abort_count", int'(sym_count), 4);
        end

        // en_p together with bit_valid: bit dropped
        begin
            start(3);
            bit_valid = 1'b1; bit_in = 1'b1;
            start(3);
            bit_valid = 1'b0;
            send_bits(16'b010, 3, 0);
            drain("collide_drain");
            chk("collide_count", int'(sym_count), 1);
        end

        // async reset mid-RUN after two symbols
        start(12);
        send_bits(16'b001011, 6, 0);
        @(negedge clk_6M); #1;
        chk("pre_rst_count", int'(sym_count), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_phase", int'(sym_phase), 0);
        chk("mid_rst_count", int'(sym_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_valid", int'(sym_valid), 0);
        chk("mid_rst_done", int'(done_p), 0);
        m_run = 0;
        @(posedge clk_6M); #1;
        rst = 1'b0;
        @(posedge clk_6M); #1;
        begin
            int d0;
            d0 = done_cnt;
            send_bits(16'b111111, 6, 0);
            drain("post_rst_drain");
            chk("post_rst_count", int'(sym_count), 0);
            chk("post_rst_busy", int'(busy), 0);
            chk("post_rst_done", done_cnt - d0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
